mem_access: RTL and testbench
=============================

// Module: mem_access
// PURPOSE
//  Memory-access / writeback stage directly downstream of the execution stage of the 16-bit core.
//  Registers the execution results and issues data-memory load/store requests over a req/ack handshake.
//  Produces the register-file write port (8 regs) and the PC redirect.
//  Stalls upstream via in_ready while a memory access is outstanding.
// PARAMETERS
//  DATA_W    16  data/address width
//  REG_AW    3   register-file address width
//  MAX_WAIT  15  max cycles in ACCESS before abort (used only with MEM_TIMEOUT_EN)
// PORTS
//  clk        in   1        clock
//  rst        in   1        synchronous, active-high reset
//  in_valid   in   1        execution outputs valid this cycle
//  in_ready   out  1        stage can accept; transfer = in_valid & in_ready at posedge
//  pc_w       in   1        branch/jump taken (from execution)
//  mem_w      in   1        store op
//  is_ld      in   1        load op
//  reg_w      in   1        op writes a register
//  result_w   in   REG_AW   destination register address
//  result     in   DATA_W   ALU result / memory address / branch target
//  rd_data    in   DATA_W   store data
//  dm_req     out  1        data-memory request, held until dm_ack
//  dm_we      out  1        1=store, 0=load; valid while dm_req
//  dm_addr    out  DATA_W   memory address
//  dm_wdata   out  DATA_W   store data
//  dm_ack     in   1        memory completes the request this cycle
//  dm_rdata   in   DATA_W   load data, valid with dm_ack
//  wb_en      out  1        register-file write strobe (1 cycle)
//  wb_addr    out  REG_AW   write address
//  wb_data    out  DATA_W   write data
//  pc_load    out  1        PC redirect strobe (1 cycle)
//  pc_target  out  DATA_W   redirect target
//  err        out  1        memory timeout pulse (1 cycle)
// BEHAVIOUR
//  FSM states IDLE, ACCESS, DONE; reset -> IDLE; all outputs and latched fields reset to 0.
//  IDLE: in_ready=1; on transfer, latch all inputs; mem op (mem_w|is_ld) -> ACCESS, else -> DONE.
//  ACCESS: in_ready=0, dm_req=1, dm_we=mem_w_q, dm_addr=result_q, dm_wdata=rd_data_q.
//   - On dm_ack: latch dm_rdata if load -> DONE; dm_req deasserts the cycle after ack.
//   - Zero-wait ack (first ACCESS cycle) is legal.
//  DONE: one cycle, registered outputs:
//   - wb_en = reg_w_q & ~mem_w_q & ~aborted; wb_addr = result_w_q.
//   - wb_data = is_ld_q ? rdata_q : result_q; pc_load = pc_w_q; pc_target = result_q.
//   - in_ready=1; a transfer in DONE goes to ACCESS/DONE (back-to-back), else -> IDLE.
//  Latency: non-mem op: transfer at edge N -> wb_en high in cycle N+1 (throughput 1/cycle).
//   Memory op: wb_en in cycle after the dm_ack edge.
//  Boundaries:
//   - mem_w & is_ld both set: store wins, no writeback.
//   - dm_ack outside ACCESS: ignored.
//   - in_valid while in_ready=0: ignored; upstream holds inputs.
//   - reg_w with result_w=0 writes normally (no special reg 0).
//   - Reset mid-ACCESS: dm_req=0 after the reset edge; transaction dropped; no wb_en/pc_load.
// CONFIGURATION
//  MEM_TIMEOUT_EN defined:
//   - Counter clears on ACCESS entry and increments each ACCESS cycle.
//   - MAX_WAIT cycles without ack -> DONE with aborted=1: err=1, wb_en=0, pc_load still honoured.
//  MEM_TIMEOUT_EN undefined: no counter; ACCESS waits indefinitely; err tied 0.
// TESTING
//  1 ALU op reg_w=1 result_w=3 result=0x1234 -> next cycle wb_en=1 wb_addr=3 wb_data=0x1234; in_ready stays 1
//  2 Load is_ld=1 result=0x0040 result_w=5, ack 2 cycles late rdata=0xBEEF
//    -> dm_req 3 cycles, dm_we=0, dm_addr=0x0040, in_ready=0; then wb_en=1 wb_addr=5 wb_data=0xBEEF
//  3 Store mem_w=1 result=0x0010 rd_data=0xA5A5, zero-wait ack
//    -> dm_we=1 dm_wdata=0xA5A5 for 1 cycle; wb_en never asserts
//  4 pc_w=1 result=0x0020 -> pc_load=1 pc_target=0x0020 for exactly 1 cycle; back-to-back ALU op next cycle also written
//  5 rst=1 during ACCESS of a load -> dm_req=0, wb_en=0, in_ready=1 after the edge; late dm_ack ignored
//  6 MEM_TIMEOUT_EN, MAX_WAIT=4, no ack -> dm_req high 4 cycles, then err=1 one cycle, wb_en=0

Source files
------------

// File: rtl/mem_access_if.sv
// mem_access_if -- bundle of the memory-access stage's handshake and bus signals.
//
// Groups three sides of the stage:
//   execution side : in_valid/in_ready handshake plus the decoded op fields
//                    (pc_w, mem_w, is_ld, reg_w, result_w, result, rd_data)
//   data memory    : dm_req/dm_ack handshake, dm_we, dm_addr, dm_wdata, dm_rdata
//   writeback      : wb_en/wb_addr/wb_data register-file port, pc_load/pc_target
//                    redirect, err timeout pulse
//
// Modports:
//   master : the mem_access stage itself
//   slave  : the surrounding environment (execution stage, memory, regfile)
interface mem_access_if #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3
) ();
    logic              in_valid;
    logic              in_ready;
    logic              pc_w;
    logic              mem_w;
    logic              is_ld;
    logic              reg_w;
    logic [REG_AW-1:0] result_w;
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] rd_data;

    logic              dm_req;
    logic              dm_we;
    logic [DATA_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_ack;
    logic [DATA_W-1:0] dm_rdata;

    logic              wb_en;
    logic [REG_AW-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              pc_load;
    logic [DATA_W-1:0] pc_target;
    logic              err;

    modport master (
        input  in_valid, pc_w, mem_w, is_ld, reg_w, result_w, result, rd_data,
        input  dm_ack, dm_rdata,
        output in_ready,
        output dm_req, dm_we, dm_addr, dm_wdata,
        output wb_en, wb_addr, wb_data, pc_load, pc_target, err
    );

    modport slave (
        output in_valid, pc_w, mem_w, is_ld, reg_w, result_w, result, rd_data,
        output dm_ack, dm_rdata,
        input  in_ready,
        input  dm_req, dm_we, dm_addr, dm_wdata,
        input  wb_en, wb_addr, wb_data, pc_load, pc_target, err
    );
endinterface

// File: rtl/mem_access.sv
// mem_access -- memory-access / writeback stage of the 16-bit core.
//
// Registers the execution-stage results, issues data-memory loads/stores over
// a req/ack handshake, and produces the register-file write port and the PC
// redirect. in_ready drops while a memory access is outstanding.
//
// Ports:
//   clk  : clock
//   rst  : synchronous, active-high reset
//   bus  : mem_access_if.master (execution handshake + op fields, data-memory
//          req/ack bus, writeback port, PC redirect, err pulse)
//
// Optional feature (macro MEM_TIMEOUT_EN): when defined, an access that sees no
// dm_ack within MAX_WAIT cycles is aborted; the DONE cycle then pulses err,
// suppresses wb_en and still honours pc_load. When undefined, ACCESS waits
// indefinitely and err is tied low.
module mem_access #(
    parameter int DATA_W   = 16,
    parameter int REG_AW   = 3,
    parameter int MAX_WAIT = 15
) (
    input logic          clk,
    input logic          rst,
    mem_access_if.master bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    state_e            state_q, state_d;

    // Fields latched on transfer; they stay stable through ACCESS and DONE.
    logic              pc_w_q, pc_w_d;
    logic              mem_w_q, mem_w_d;
    logic              is_ld_q, is_ld_d;
    logic              reg_w_q, reg_w_d;
    logic [REG_AW-1:0] result_w_q, result_w_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;

    // Registered outputs.
    logic              dm_req_q, dm_req_d;
    logic              wb_en_q, wb_en_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic              pc_load_q, pc_load_d;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic              err_q, err_d;
`else
    logic              unused_max_wait;
    assign unused_max_wait = ^MAX_WAIT;
`endif

    always_comb begin
        state_d    = state_q;
        pc_w_d     = pc_w_q;
        mem_w_d    = mem_w_q;
        is_ld_d    = is_ld_q;
        reg_w_d    = reg_w_q;
        result_w_d = result_w_q;
        result_d   = result_q;
        rd_data_d  = rd_data_q;
        dm_req_d   = dm_req_q;
        wb_en_d    = 1'b0;
        wb_data_d  = wb_data_q;
        pc_load_d  = 1'b0;
`ifdef MEM_TIMEOUT_EN
        wait_cnt_d = wait_cnt_q;
        err_d      = 1'b0;
`endif

        case (state_q)
            ACCESS: begin
                if (bus.dm_ack) begin
                    state_d   = DONE;
                    dm_req_d  = 1'b0;
                    // A store (even with is_ld also set) never writes back.
                    wb_en_d   = reg_w_q & ~mem_w_q;
                    wb_data_d = is_ld_q ? bus.dm_rdata : result_q;
                    pc_load_d = pc_w_q;
`ifdef MEM_TIMEOUT_EN
                end else if (wait_cnt_q == CNT_W'(MAX_WAIT - 1)) begin
                    // Last allowed cycle without ack: abort the access.
                    state_d   = DONE;
                    dm_req_d  = 1'b0;
                    err_d     = 1'b1;
                    pc_load_d = pc_w_q;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
`endif
                end
            end

            // IDLE and DONE both accept a new op; DONE without a transfer falls to IDLE.
            default: begin
                if (bus.in_valid) begin
                    pc_w_d     = bus.pc_w;
                    mem_w_d    = bus.mem_w;
                    is_ld_d    = bus.is_ld;
                    reg_w_d    = bus.reg_w;
                    result_w_d = bus.result_w;
                    result_d   = bus.result;
                    rd_data_d  = bus.rd_data;
                    if (bus.mem_w | bus.is_ld) begin
                        state_d    = ACCESS;
                        dm_req_d   = 1'b1;
`ifdef MEM_TIMEOUT_EN
                        wait_cnt_d = '0;
`endif
                    end else begin
                        state_d   = DONE;
                        wb_en_d   = bus.reg_w;
                        wb_data_d = bus.result;
                        pc_load_d = bus.pc_w;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_w_q     <= 1'b0;
            mem_w_q    <= 1'b0;
            is_ld_q    <= 1'b0;
            reg_w_q    <= 1'b0;
            result_w_q <= '0;
            result_q   <= '0;
            rd_data_q  <= '0;
            dm_req_q   <= 1'b0;
            wb_en_q    <= 1'b0;
            wb_data_q  <= '0;
            pc_load_q  <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pc_w_q     <= pc_w_d;
            mem_w_q    <= mem_w_d;
            is_ld_q    <= is_ld_d;
            reg_w_q    <= reg_w_d;
            result_w_q <= result_w_d;
            result_q   <= result_d;
            rd_data_q  <= rd_data_d;
            dm_req_q   <= dm_req_d;
            wb_en_q    <= wb_en_d;
            wb_data_q  <= wb_data_d;
            pc_load_q  <= pc_load_d;
`ifdef MEM_TIMEOUT_EN
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
`endif
        end
    end

    // in_ready is a pure state decode so it reads 1 straight out of reset.
    assign bus.in_ready  = (state_q != ACCESS);
    assign bus.dm_req    = dm_req_q;
    assign bus.dm_we     = mem_w_q;
    assign bus.dm_addr   = result_q;
    assign bus.dm_wdata  = rd_data_q;
    assign bus.wb_en     = wb_en_q;
    assign bus.wb_addr   = result_w_q;
    assign bus.wb_data   = wb_data_q;
    assign bus.pc_load   = pc_load_q;
    assign bus.pc_target = result_q;
`ifdef MEM_TIMEOUT_EN
    assign bus.err       = err_q;
`else
    assign bus.err       = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access -- directed, table-driven bench for mem_access.
// Inputs are driven and outputs sampled on the falling edge.
module tb_mem_access;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mem_access_if #(.DATA_W(16), .REG_AW(3)) bus ();

    mem_access #(.DATA_W(16), .REG_AW(3), .MAX_WAIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    typedef struct {
        string       name;
        logic        iv, pcw, mw, ld, rw;
        logic [2:0]  rwa;
        logic [15:0] res, rd;
        logic        ack;
        logic [15:0] rdata;
        // expected after the edge
        logic        e_rdy, e_req, e_we;
        logic [15:0] e_addr, e_wdata;
        logic        e_wb;
        logic [2:0]  e_wba;
        logic [15:0] e_wbd;
        logic        e_pcl;
        logic [15:0] e_pct;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic pcw, input logic mw, input logic ld,
                         input logic rw, input logic [2:0] rwa, input logic [15:0] res,
                         input logic [15:0] rd, input logic ack, input logic [15:0] rdata);
        bus.in_valid = iv;  bus.pc_w = pcw;  bus.mem_w = mw;  bus.is_ld = ld;
        bus.reg_w = rw;     bus.result_w = rwa;  bus.result = res;  bus.rd_data = rd;
        bus.dm_ack = ack;   bus.dm_rdata = rdata;
    endtask

    task automatic idle_in();
        drive(0, 0, 0, 0, 0, 3'd0, 16'h0, 16'h0, 0, 16'h0);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic vec_t mk(input string name,
        input logic iv, input logic pcw, input logic mw, input logic ld, input logic rw,
        input logic [2:0] rwa, input logic [15:0] res, input logic [15:0] rd,
        input logic ack, input logic [15:0] rdata,
        input logic e_rdy, input logic e_req, input logic e_we,
        input logic [15:0] e_addr, input logic [15:0] e_wdata,
        input logic e_wb, input logic [2:0] e_wba, input logic [15:0] e_wbd,
        input logic e_pcl, input logic [15:0] e_pct);
        vec_t v;
        v.name = name; v.iv = iv; v.pcw = pcw; v.mw = mw; v.ld = ld; v.rw = rw;
        v.rwa = rwa; v.res = res; v.rd = rd; v.ack = ack; v.rdata = rdata;
        v.e_rdy = e_rdy; v.e_req = e_req; v.e_we = e_we; v.e_addr = e_addr;
        v.e_wdata = e_wdata; v.e_wb = e_wb; v.e_wba = e_wba; v.e_wbd = e_wbd;
        v.e_pcl = e_pcl; v.e_pct = e_pct;
        return v;
    endfunction

    initial begin
        //            name        iv pc mw ld rw rwa  result    rd_data  ack rdata     rdy req we addr      wdata    wb wba  wbd       pcl pct
        vecs[0]  = mk("alu_r3",    1, 0, 0, 0, 1, 3'd3, 16'h1234, 16'h0,   0, 16'h0,     1, 0, 0, 16'h0,    16'h0,   1, 3'd3, 16'h1234, 0, 16'h0);
        vecs[1]  = mk("ld_issue",  1, 0, 0, 1, 1, 3'd5, 16'h0040, 16'h0,   0, 16'h0,     0, 1, 0, 16'h0040, 16'h0,   0, 3'd0, 16'h0,    0, 16'h0);
        vecs[2]  = mk("ld_wait1",  1, 0, 0, 0, 1, 3'd7, 16'h7777, 16'h0,   0, 16'h0,     0, 1, 0, 16'h0040, 16'h0,   0, 3'd0, 16'h0,    0, 16'h0);
        vecs[3]  = mk("ld_wait2",  0, 0, 0, 0, 0, 3'd0, 16'h0,    16'h0,   0, 16'h0,     0, 1, 0, 16'h0040, 16'h0,   0, 3'd0, 16'h0,    0, 16'h0);
        vecs[4]  = mk("ld_ack",    0, 0, 0, 0, 0, 3'd0, 16'h0,    16'h0,   1, 16'hBEEF,  1, 0, 0, 16'h0,    16'h0,   1, 3'd5, 16'hBEEF, 0, 16'h0);
        vecs[5]  = mk("st_issue",  1, 0, 1, 0, 1, 3'd1, 16'h0010, 16'hA5A5,0, 16'h0,     0, 1, 1, 16'h0010, 16'hA5A5,0, 3'd0, 16'h0,    0, 16'h0);
        vecs[6]  = mk("st_ack0",   0, 0, 0, 0, 0, 3'd0, 16'h0,    16'h0,   1, 16'h9999,  1, 0, 0, 16'h0,    16'h0,   0, 3'd0, 16'h0,    0, 16'h0);
        vecs[7]  = mk("branch",    1, 1, 0, 0, 0, 3'd0, 16'h0020, 16'h0,   0, 16'h0,     1, 0, 0, 16'h0,    16'h0,   0, 3'd0, 16'h0,    1, 16'h0020);
        vecs[8]  = mk("alu_r0",    1, 0, 0, 0, 1, 3'd0, 16'h5A5A, 16'h0,   0, 16'h0,     1, 0, 0, 16'h0,    16'h0,   1, 3'd0, 16'h5A5A, 0, 16'h0);
        vecs[9]  = mk("stray_ack", 0, 0, 0, 0, 0, 3'd0, 16'h0,    16'h0,   1, 16'h4444,  1, 0, 0, 16'h0,    16'h0,   0, 3'd0, 16'h0,    0, 16'h0);
        vecs[10] = mk("stld_iss",  1, 0, 1, 1, 1, 3'd2, 16'h0100, 16'h1111,0, 16'h0,     0, 1, 1, 16'h0100, 16'h1111,0, 3'd0, 16'h0,    0, 16'h0);
        vecs[11] = mk("stld_ack",  0, 0, 0, 0, 0, 3'd0, 16'h0,    16'h0,   1, 16'hDEAD,  1, 0, 0, 16'h0,    16'h0,   0, 3'd0, 16'h0,    0, 16'h0);
        vecs[12] = mk("idle",      0, 0, 0, 0, 0, 3'd0, 16'h0,    16'h0,   0, 16'h0,     1, 0, 0, 16'h0,    16'h0,   0, 3'd0, 16'h0,    0, 16'h0);
        vecs[13] = mk("jal",       1, 1, 0, 0, 1, 3'd6, 16'h0ABC, 16'h0,   0, 16'h0,     1, 0, 0, 16'h0,    16'h0,   1, 3'd6, 16'h0ABC, 1, 16'h0ABC);

        idle_in();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_dm_req",   bus.dm_req,   0);
        chk("rst_dm_addr",  bus.dm_addr,  0);
        chk("rst_wb_en",    bus.wb_en,    0);
        chk("rst_wb_data",  bus.wb_data,  0);
        chk("rst_pc_load",  bus.pc_load,  0);
        chk("rst_err",      bus.err,      0);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].iv, vecs[i].pcw, vecs[i].mw, vecs[i].ld, vecs[i].rw,
                  vecs[i].rwa, vecs[i].res, vecs[i].rd, vecs[i].ack, vecs[i].rdata);
            tick();
            chk({vecs[i].name, "_in_ready"}, bus.in_ready, vecs[i].e_rdy);
            chk({vecs[i].name, "_dm_req"},   bus.dm_req,   vecs[i].e_req);
            if (vecs[i].e_req) begin
                chk({vecs[i].name, "_dm_we"},   bus.dm_we,   vecs[i].e_we);
                chk({vecs[i].name, "_dm_addr"}, bus.dm_addr, vecs[i].e_addr);
                if (vecs[i].e_we)
                    chk({vecs[i].name, "_dm_wdata"}, bus.dm_wdata, vecs[i].e_wdata);
            end
            chk({vecs[i].name, "_wb_en"}, bus.wb_en, vecs[i].e_wb);
            if (vecs[i].e_wb) begin
                chk({vecs[i].name, "_wb_addr"}, bus.wb_addr, vecs[i].e_wba);
                chk({vecs[i].name, "_wb_data"}, bus.wb_data, vecs[i].e_wbd);
            end
            chk({vecs[i].name, "_pc_load"}, bus.pc_load, vecs[i].e_pcl);
            if (vecs[i].e_pcl)
                chk({vecs[i].name, "_pc_target"}, bus.pc_target, vecs[i].e_pct);
            chk({vecs[i].name, "_err"}, bus.err, 0);
        end

        // Reset in the middle of a load access, then a late ack.
        drive(1, 0, 0, 1, 1, 3'd4, 16'h0200, 16'h0, 0, 16'h0);
        tick();
        chk("rstmid_req_before", bus.dm_req,   1);
        chk("rstmid_rdy_before", bus.in_ready, 0);
        idle_in();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstmid_req",   bus.dm_req,   0);
        chk("rstmid_wb_en", bus.wb_en,    0);
        chk("rstmid_rdy",   bus.in_ready, 1);
        chk("rstmid_pcl",   bus.pc_load,  0);
        drive(0, 0, 0, 0, 0, 3'd0, 16'h0, 16'h0, 1, 16'hFFFF);
        tick();
        chk("lateack_wb_en", bus.wb_en,    0);
        chk("lateack_req",   bus.dm_req,   0);
        chk("lateack_rdy",   bus.in_ready, 1);
        idle_in();
        tick();

`ifdef MEM_TIMEOUT_EN
        // No ack: four ACCESS cycles, then an aborted DONE.
        drive(1, 1, 0, 1, 1, 3'd3, 16'h0300, 16'h0, 0, 16'h0);
        tick();
        idle_in();
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("to_req_c%0d", c), bus.dm_req, 1);
            chk($sformatf("to_err_c%0d", c), bus.err,    0);
            tick();
        end
        chk("to_req_end",  bus.dm_req,    0);
        chk("to_err",      bus.err,       1);
        chk("to_wb_en",    bus.wb_en,     0);
        chk("to_pc_load",  bus.pc_load,   1);
        chk("to_pc_tgt",   bus.pc_target, 16'h0300);
        chk("to_rdy",      bus.in_ready,  1);
        tick();
        chk("to_err_pulse", bus.err, 0);
`else
        // No timeout: the access just keeps waiting.
        drive(1, 0, 0, 1, 1, 3'd3, 16'h0300, 16'h0, 0, 16'h0);
        tick();
        idle_in();
        for (int c = 0; c < 8; c++) begin
            chk($sformatf("wait_req_c%0d", c), bus.dm_req, 1);
            chk($sformatf("wait_err_c%0d", c), bus.err,    0);
            tick();
        end
        drive(0, 0, 0, 0, 0, 3'd0, 16'h0, 16'h0, 1, 16'h0C0D);
        tick();
        idle_in();
        chk("wait_wb_en",   bus.wb_en,   1);
        chk("wait_wb_addr", bus.wb_addr, 3);
        chk("wait_wb_data", bus.wb_data, 16'h0C0D);
        chk("wait_err",     bus.err,     0);
        tick();
        chk("wait_wb_pulse", bus.wb_en, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
